ifu_pc_stage: RTL and testbench

IFU_PC_STAGE -- requirements
Module: ifu_pc_stage

---
 rtl/ifu_pc_stage_pkg.sv | 22 ++
 rtl/ifu_pc_stage_if.sv | 27 ++
 rtl/ifu_pc_stage_npc_mux.sv | 28 ++
 rtl/ifu_pc_stage.sv | 53 +++++
 tb/tb_ifu_pc_stage.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/ifu_pc_stage_pkg.sv
// Shared fetch-stage constants and types. The controller uses the same
// next-PC select encodings.
package ifu_pc_stage_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        NPC_SEL_SEQ = 2'b00,
        NPC_SEL_BR  = 2'b01,
        NPC_SEL_J   = 2'b10,
        NPC_SEL_JR  = 2'b11
    } npc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/ifu_pc_stage_if.sv
// Fetch-stage bus: D-stage redirect controls and imem data in, PC and IF/ID
// contents out.
interface ifu_pc_stage_if;

    logic        stall;
    logic [1:0]  npc_sel;
    logic [31:0] br_target;
    logic [25:0] j_index;
    logic [31:0] jr_addr;
    logic [31:0] im_instr;
    logic [31:0] pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic        valid_d;

    modport master (
        output stall, npc_sel, br_target, j_index, jr_addr, im_instr,
        input  pc, instr_d, pc_d, pc4_d, valid_d
    );

    modport slave (
        input  stall, npc_sel, br_target, j_index, jr_addr, im_instr,
        output pc, instr_d, pc_d, pc4_d, valid_d
    );

endinterface

// File: rtl/ifu_pc_stage_npc_mux.sv
// Combinational next-PC selector. Jump region bits come from the D-stage
// PC+4, i.e. the delay slot address.
module npc_mux
    import ifu_pc_stage_pkg::*;
(
    input  logic [1:0]  npc_sel,
    input  logic [31:0] pc4,
    input  logic [31:0] pc4_d,
    input  logic [31:0] br_target,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_addr,
    output logic [31:0] npc
);

    logic unused_bits;
    assign unused_bits = ^{jr_addr[1:0], pc4_d[27:0]};

    always_comb begin
        npc = pc4;
        unique case (npc_sel)
            NPC_SEL_SEQ: npc = pc4;
            NPC_SEL_BR:  npc = br_target;
            NPC_SEL_J:   npc = {pc4_d[31:28], j_index, 2'b00};
            NPC_SEL_JR:  npc = {jr_addr[31:2], 2'b00};
        endcase
    end

endmodule

// File: rtl/ifu_pc_stage.sv
// Fetch stage: PC register, next-PC mux and IF/ID pipeline register.
// pc comes straight from a flop, so no input reaches it combinationally.
module ifu_pc_stage
    import ifu_pc_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ifu_pc_stage_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] pc4;
    logic [31:0] npc;
    ifid_t       ifid_q;

    assign pc4 = pc_q + PC_STEP;

    npc_mux u_npc_mux (
        .npc_sel   (bus.npc_sel),
        .pc4       (pc4),
        .pc4_d     (ifid_q.pc4),
        .br_target (bus.br_target),
        .j_index   (bus.j_index),
        .jr_addr   (bus.jr_addr),
        .npc       (npc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else if (!bus.stall) begin
            pc_q <= npc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_q <= '0;
        end else if (!bus.stall) begin
            ifid_q.instr <= bus.im_instr;
            ifid_q.pc    <= pc_q;
            ifid_q.pc4   <= pc4;
            ifid_q.valid <= 1'b1;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.instr_d = ifid_q.instr;
    assign bus.pc_d    = ifid_q.pc;
    assign bus.pc4_d   = ifid_q.pc4;
    assign bus.valid_d = ifid_q.valid;

endmodule

// File: tb/tb_ifu_pc_stage.sv
// Directed bench for ifu_pc_stage: a vector table walked edge by edge plus
// hand-written reset/stall sequences.
module tb_ifu_pc_stage;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ifu_pc_stage_if bus ();

    ifu_pc_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h2400_0000 ^ {a[15:0], a[15:0]} ^ {8'h0, a[31:24], 16'h0};
    endfunction

    always_comb bus.im_instr = imem(bus.pc);

    typedef struct {
        bit          rst_before;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] br;
        logic [25:0] ji;
        logic [31:0] jr;
        logic [31:0] e_pc;
        logic [31:0] e_pcd;
        logic [31:0] e_pc4d;
        logic        e_v;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pcd,
                           input logic [31:0] e_pc4d, input logic e_v);
        chk({tag, " pc"}, bus.pc, e_pc);
        chk({tag, " pc_d"}, bus.pc_d, e_pcd);
        chk({tag, " pc4_d"}, bus.pc4_d, e_pc4d);
        chk({tag, " valid_d"}, {31'b0, bus.valid_d}, {31'b0, e_v});
        chk({tag, " instr_d"}, bus.instr_d, e_v ? imem(e_pcd) : 32'h0);
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic [31:0] br,
                         input logic [25:0] ji, input logic [31:0] jr);
        bus.stall     = st;
        bus.npc_sel   = sel;
        bus.br_target = br;
        bus.j_index   = ji;
        bus.jr_addr   = jr;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //          rst  st  sel    br             ji        jr            pc            pc_d          pc4_d        v
        vecs[0]  = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 1};
        vecs[1]  = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_3008, 32'h0000_3004, 32'h0000_3008, 1};
        vecs[2]  = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_300C, 32'h0000_3008, 32'h0000_300C, 1};
        vecs[3]  = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_3010, 32'h0000_300C, 32'h0000_3010, 1};
        vecs[4]  = '{0, 0, 2'b10, 32'h0,        26'hC40,  32'h0,        32'h0000_3100, 32'h0000_3010, 32'h0000_3014, 1};
        vecs[5]  = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_3104, 32'h0000_3100, 32'h0000_3104, 1};
        vecs[6]  = '{0, 0, 2'b11, 32'h0,        26'h0,    32'h0000_3207, 32'h0000_3204, 32'h0000_3104, 32'h0000_3108, 1};
        vecs[7]  = '{0, 1, 2'b01, 32'h4000,     26'h0,    32'h0,        32'h0000_3204, 32'h0000_3104, 32'h0000_3108, 1};
        vecs[8]  = '{0, 1, 2'b01, 32'h4000,     26'h0,    32'h0,        32'h0000_3204, 32'h0000_3104, 32'h0000_3108, 1};
        vecs[9]  = '{0, 1, 2'b01, 32'h4000,     26'h0,    32'h0,        32'h0000_3204, 32'h0000_3104, 32'h0000_3108, 1};
        vecs[10] = '{0, 0, 2'b01, 32'h4000,     26'h0,    32'h0,        32'h0000_4000, 32'h0000_3204, 32'h0000_3208, 1};
        vecs[11] = '{0, 0, 2'b11, 32'h0,        26'h0,    32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_4000, 32'h0000_4004, 1};
        vecs[12] = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1};
        vecs[13] = '{1, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 1};
        vecs[14] = '{0, 0, 2'b00, 32'h0,        26'h0,    32'h0,        32'h0000_3008, 32'h0000_3004, 32'h0000_3008, 1};
        vecs[15] = '{0, 0, 2'b01, 32'h3100,     26'h0,    32'h0,        32'h0000_3100, 32'h0000_3008, 32'h0000_300C, 1};
        vecs[16] = '{0, 0, 2'b10, 32'h0,        26'h800,  32'h0,        32'h0000_2000, 32'h0000_3100, 32'h0000_3104, 1};

        // Reset asserted before any edge, then held across one edge.
        reset = 1'b1;
        drive(1'b0, 2'b01, 32'h4000, 26'h0, 32'h0);
        #1;
        chk_all("reset async", 32'h0000_3000, 32'h0, 32'h0, 1'b0);
        #11;
        chk_all("reset held", 32'h0000_3000, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst_before) begin
                reset = 1'b1;
                #1;
                chk_all($sformatf("v%0d midrun reset", i), 32'h0000_3000, 32'h0, 32'h0, 1'b0);
                #1;
                reset = 1'b0;
            end
            drive(vecs[i].stall, vecs[i].sel, vecs[i].br, vecs[i].ji, vecs[i].jr);
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_pcd, vecs[i].e_pc4d, vecs[i].e_v);
        end

        // Reset during a stalled redirect, stall still held on the first edge after release.
        drive(1'b1, 2'b01, 32'h4000, 26'h0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("stall+reset", 32'h0000_3000, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_all("stall first edge", 32'h0000_3000, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("release first fetch", 32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 1'b1);

        // Jump region bits come from pc4_d: fetch at 0xFFFFFFF8 puts 0xFFFFFFFC there.
        drive(1'b0, 2'b11, 32'h0, 26'h0, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("pre-jump pc4_d", bus.pc4_d, 32'hFFFF_FFFC);
        drive(1'b0, 2'b10, 32'h0, 26'h0000123, 32'h0);
        @(posedge clk);
        #1;
        chk("jump region pc", bus.pc, 32'hF000_048C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
